// File: rtl/regfile_read_bypass.sv
// Integer register file: 32 x 64-bit, one write port, two combinational read ports
// with same-cycle write-to-read bypass. Index ZERO_REG is hardwired to zero.

module regfile_enreg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       data_q <= '0;
    else if (en_i) data_q <= d_i;
  end

  assign q_o = data_q;
endmodule

// Binary 2:1 mux tree; level l merges pairs of level l-1 using address bit l-1.
module regfile_read_mux #(
  parameter int WIDTH = 64,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic [AW-1:0]    sel_i,
  input  logic [WIDTH-1:0] regs_i [NREGS],
  output logic [WIDTH-1:0] data_o
);
  for (genvar l = 0; l <= AW; l++) begin : lvl
    logic [WIDTH-1:0] data [NREGS >> l];
    if (l == 0) begin : g_leaf
      for (genvar k = 0; k < NREGS; k++) begin : g_k
        assign data[k] = regs_i[k];
      end
    end else begin : g_node
      for (genvar k = 0; k < (NREGS >> l); k++) begin : g_k
        assign data[k] = sel_i[l-1] ? lvl[l-1].data[2*k+1] : lvl[l-1].data[2*k];
      end
    end
  end

  assign data_o = lvl[AW].data[0];
endmodule

module regfile_read_bypass #(
  parameter int WIDTH    = 64,
  parameter int NREGS    = 32,
  parameter int ZERO_REG = 31
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     RegWrite,
  input  logic [$clog2(NREGS)-1:0] WriteRegister,
  input  logic [WIDTH-1:0]         WriteData,
  input  logic [$clog2(NREGS)-1:0] ReadRegister1,
  input  logic [$clog2(NREGS)-1:0] ReadRegister2,
  output logic [WIDTH-1:0]         ReadData1,
  output logic [WIDTH-1:0]         ReadData2
);
  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_A = AW'(ZERO_REG);

  logic [WIDTH-1:0] reg_val [NREGS];
  logic [WIDTH-1:0] mux1, mux2;
  logic             byp1, byp2;

  // The zero register has no storage; its mux leaf is tied to zero.
  for (genvar i = 0; i < NREGS; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign reg_val[i] = '0;
    end else begin : g_store
      logic wr_en;
      assign wr_en = RegWrite && (WriteRegister == AW'(i));
      regfile_enreg #(.WIDTH(WIDTH)) u_reg (
        .clk  (clk),
        .rst  (rst),
        .en_i (wr_en),
        .d_i  (WriteData),
        .q_o  (reg_val[i])
      );
    end
  end

  regfile_read_mux #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_mux1 (
    .sel_i  (ReadRegister1),
    .regs_i (reg_val),
    .data_o (mux1)
  );

  regfile_read_mux #(.WIDTH(WIDTH), .NREGS(NREGS), .AW(AW)) u_mux2 (
    .sel_i  (ReadRegister2),
    .regs_i (reg_val),
    .data_o (mux2)
  );

  assign byp1 = RegWrite && (WriteRegister == ReadRegister1);
  assign byp2 = RegWrite && (WriteRegister == ReadRegister2);

  // Reset forces zero even on a bypass match, since storage is being cleared.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (!rst && ReadRegister1 != ZERO_A) ReadData1 = byp1 ? WriteData : mux1;
    if (!rst && ReadRegister2 != ZERO_A) ReadData2 = byp2 ? WriteData : mux2;
  end
endmodule

// File: tb/tb_regfile_read_bypass.sv
// Directed and randomized checks of regfile_read_bypass against an array model.
`timescale 1ns/1ps

module tb_regfile_read_bypass;
  logic        clk;
  logic        rst;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [63:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [63:0] ReadData1;
  logic [63:0] ReadData2;

  int n_tests = 0;
  int n_fail  = 0;
  logic [63:0] model [32];

  regfile_read_bypass dut (
    .clk           (clk),
    .rst           (rst),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference: zero register, then in-flight write, then stored value
  function automatic logic [63:0] exp_read(input logic [4:0] a);
    if (rst) return 64'h0;
    if (a == 5'd31) return 64'h0;
    if (RegWrite === 1'b1 && WriteRegister === a) return WriteData;
    return model[a];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_ports(input string tag);
    check({tag, "_p1"}, ReadData1, exp_read(ReadRegister1));
    check({tag, "_p2"}, ReadData2, exp_read(ReadRegister2));
  endtask

  task automatic drive(input logic we, input logic [4:0] wa, input logic [63:0] wd,
                       input logic [4:0] r1, input logic [4:0] r2);
    RegWrite = we; WriteRegister = wa; WriteData = wd;
    ReadRegister1 = r1; ReadRegister2 = r2;
    #1;
  endtask

  // one rising edge; model commits the write seen at the edge, then settle past it
  task automatic cycle();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 64'h0;
    end else if (RegWrite === 1'b1 && WriteRegister !== 5'd31) begin
      model[WriteRegister] = WriteData;
    end
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 64'h0;
  endtask

  initial begin
    clear_model();
    rst = 1'b1;
    drive(1'b0, 5'd0, 64'h0, 5'd3, 5'd4);
    cycle(); cycle();
    check("in_reset", ReadData1, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // 1: every index reads zero after reset
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 5'd0, 64'h0, 5'(i), 5'(31 - i));
      check("post_reset_p1", ReadData1, 64'h0);
      check("post_reset_p2", ReadData2, 64'h0);
    end

    // 2: basic write then read
    @(negedge clk);
    drive(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF, 5'd5, 5'd6);
    check_ports("wr5_bypass");
    cycle();
    drive(1'b0, 5'd5, 64'h0, 5'd5, 5'd6);
    check("wr5_p1", ReadData1, 64'h0123_4567_89AB_CDEF);
    check("wr5_p2", ReadData2, 64'h0);

    // 3: zero register ignores writes and never bypasses
    @(negedge clk);
    drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31);
    check("xzr_pre_p1", ReadData1, 64'h0);
    check("xzr_pre_p2", ReadData2, 64'h0);
    cycle();
    check("xzr_post_p1", ReadData1, 64'h0);
    check("xzr_post_p2", ReadData2, 64'h0);
    drive(1'b0, 5'd0, 64'h0, 5'd5, 5'd30);
    check("xzr_no_side_p1", ReadData1, 64'h0123_4567_89AB_CDEF);
    check("xzr_no_side_p2", ReadData2, 64'h0);

    // 4: bypass across the write edge
    @(negedge clk);
    drive(1'b1, 5'd7, 64'h11, 5'd0, 5'd0);
    cycle();
    drive(1'b1, 5'd7, 64'h22, 5'd7, 5'd7);
    check("byp_pre_p1", ReadData1, 64'h22);
    check("byp_pre_p2", ReadData2, 64'h22);
    cycle();
    drive(1'b0, 5'd7, 64'h22, 5'd7, 5'd7);
    check("byp_post_p1", ReadData1, 64'h22);
    check("byp_post_p2", ReadData2, 64'h22);

    // 5: RegWrite low blocks writes, including unknown address/data
    @(negedge clk);
    drive(1'b0, 5'd9, 64'hDEAD, 5'd9, 5'd7);
    check("nowr_pre", ReadData1, 64'h0);
    cycle();
    check("nowr_post", ReadData1, 64'h0);
    drive(1'b0, 5'bx, 64'bx, 5'd5, 5'd7);
    cycle();
    check("nowr_x_p1", ReadData1, 64'h0123_4567_89AB_CDEF);
    check("nowr_x_p2", ReadData2, 64'h22);

    // 6: fill X0..X30, then asynchronous reset between edges
    for (int i = 0; i < 31; i++) begin
      @(negedge clk);
      drive(1'b1, 5'(i), 64'(i) * 64'h0101, 5'(i), 5'(30 - i));
      check_ports("fill");
      cycle();
    end
    @(negedge clk);
    drive(1'b0, 5'd0, 64'h0, 5'd30, 5'd2);
    check("fill_x30", ReadData1, 64'd30 * 64'h0101);
    check("fill_x2", ReadData2, 64'h0202);
    #0.5;
    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ReadRegister1 = 5'(i);
      ReadRegister2 = 5'(31 - i);
      #0.05;
      check("async_rst_p1", ReadData1, 64'h0);
      check("async_rst_p2", ReadData2, 64'h0);
    end
    RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 64'hFF; ReadRegister1 = 5'd3;
    #0.05;
    check("rst_no_bypass", ReadData1, 64'h0);
    cycle();
    clear_model();
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 5'd0, 64'h0, 5'd3, 5'd12);
    check("rst_wins_p1", ReadData1, 64'h0);
    check("rst_wins_p2", ReadData2, 64'h0);

    // randomized traffic against the array model
    for (int n = 0; n < 400; n++) begin
      logic [4:0] wa, r1, r2;
      @(negedge clk);
      wa = 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      r2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 1)), wa, {$urandom, $urandom}, r1, r2);
      check_ports("rand");
      cycle();
      check_ports("rand_post");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_read_bypass.md
Name: regfile_read_bypass

Overview:
- ARMv8-style integer register file for the pipelined CPU datapath: 32 x 64-bit architectural registers, one write port, two read ports.
- It is the read-side counterpart of the single 64-bit enabled register.
  - Storage is an array of enabled 64-bit registers.
  - A write-port decoder drives the per-register enables.
  - Each read port has a 32:1 selector with same-cycle write-to-read bypass, so decode sees the value being written back in the same cycle.
- Sits between the ID stage (read addresses) and the WB stage (write address/data).

Parameters:
- WIDTH, 64, data width of each register and of all data ports.
- NREGS, 32, number of architectural registers; address width is log2(NREGS) = 5.
- ZERO_REG, 31, index of the hardwired zero register (XZR).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset; clears all storage.
- RegWrite  input  1  write enable for the write port.
- WriteRegister  input  5  destination register index.
- WriteData  input  WIDTH  data to write.
- ReadRegister1  input  5  read port 1 source index.
- ReadRegister2  input  5  read port 2 source index.
- ReadData1  output  WIDTH  read port 1 data.
- ReadData2  output  WIDTH  read port 2 data.

Behaviour:
- Reset:
  - rst high asynchronously forces every storage register to 0, independent of clk.
  - While rst is high, ReadData1 and ReadData2 = 0 for all addresses, and bypass is disabled.
  - Deasserting rst does not write anything.
- Write:
  - On a rising clk edge with RegWrite=1 and WriteRegister != ZERO_REG, register[WriteRegister] <= WriteData.
  - All other registers hold their value; each register's enable is one-hot, decoded from WriteRegister AND RegWrite.
- Write to ZERO_REG: no register changes, and no bypass occurs.
- RegWrite=0: no register changes regardless of WriteRegister/WriteData (including X on those inputs).
- Read (combinational, zero-cycle latency), evaluated independently per port p in {1,2}:
  - If ReadRegisterp == ZERO_REG -> ReadDatap = 0.
  - Else if RegWrite=1 and WriteRegister == ReadRegisterp -> ReadDatap = WriteData (bypass of the in-flight write).
  - Else -> ReadDatap = register[ReadRegisterp].
- Both ports may read the same index simultaneously; both return identical data, and both bypass if matched.
- After the write edge, the stored value equals the previously bypassed value, so the output is stable across the edge when inputs are unchanged.
- Storage: built from the existing 64-bit enabled register instances (one per index 0..30); index 31 has no storage.
- Read selection: a mux tree (5 levels of 2:1) per port. No behavioural case/array indexing in the read path.
- Timing contract: read address to ReadData is a pure combinational path. WriteData/RegWrite/WriteRegister to ReadData is also combinational (bypass path).
- Mid-operation reset: if rst asserts in the same cycle as a write, reset wins; the register reads 0 afterwards.

Test Plan:
1. Assert rst, then release. Read all 32 indices on both ports -> every ReadData = 64'h0.
2. Write 64'h0123_4567_89AB_CDEF to X5 with RegWrite=1, then set RegWrite=0 and read X5 on port1 and X6 on port2 -> ReadData1 = 64'h0123_4567_89AB_CDEF, ReadData2 = 0.
3. Set RegWrite=1, WriteRegister=31, WriteData=64'hFFFF_FFFF_FFFF_FFFF; read X31 on both ports before and after the edge -> both always 0.
4. Bypass check:
   - Preload X7 = 64'h11.
   - Then, in one cycle, drive RegWrite=1, WriteRegister=7, WriteData=64'h22, ReadRegister1=7, ReadRegister2=7.
   - Before the edge -> both ports = 64'h22.
   - After the edge with RegWrite=0 -> both = 64'h22.
5. Drive RegWrite=0, WriteRegister=9, WriteData=64'hDEAD, ReadRegister1=9 across an edge -> ReadData1 stays at the prior X9 value (0 after reset).
6. Write distinct values i*64'h0101 to X0..X30. Pulse rst asynchronously between clock edges -> all reads return 0 immediately, before the next clk edge.
